vedic_mul_pipe: RTL and testbench

//  Parametrised, fully pipelined Urdhva-Tiryagbhyam (vedic) multiplier. Successor to the fixed 4x4 unit.

---
 rtl/vedic_mul_pipe.sv | 174 +++++++++++++++++
 tb/tb_vedic_mul_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul_pipe.sv
// vedic_mul_pipe
//   Fully pipelined Urdhva-Tiryagbhyam multiplier with valid/ready flow control,
//   per-beat signed/unsigned mode and a pass-through sideband tag.
//
//   Pipeline (LVLS = log2(WIDTH), LATENCY = LVLS + 2 stages):
//     stage 1            : operand magnitudes + product sign
//     stage 2..LVLS+1    : one vedic level each (2x2 leaves, then 4x4, 8x8, ...)
//     stage LVLS+2       : sign restore, drives out_p / out_tag
//
//   Handshake: a beat moves on an edge where valid & ready are both 1.
//   The whole pipe advances together (adv = ~out_valid | out_ready); when
//   adv = 0 every register holds, so out_p / out_tag stay stable while the
//   downstream stalls. in_ready is held low until the first edge after reset.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operand beat handshake
//     in_a, in_b            operands (WIDTH bits)
//     in_signed             1: operands are two's complement
//     in_tag                sideband returned with the product
//     out_valid / out_ready product beat handshake
//     out_p                 2*WIDTH-bit product
//     out_tag               tag of this product
module vedic_mul_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int LVLS    = $clog2(WIDTH);
  localparam int LATENCY = LVLS + 2;

  logic                 init_q;
  logic                 adv;
  logic                 accept;
  logic [LATENCY:1]     vld_q;
  logic [LVLS+1:1]      neg_q;
  logic [TAG_W-1:0]     tag_q [1:LATENCY];
  logic [WIDTH-1:0]     mag_a_d, mag_b_d, mag_a_q, mag_b_q;
  logic                 neg_d;
  logic [2*WIDTH-1:0]   p_mag;
  logic [2*WIDTH-1:0]   out_p_d, out_p_q;

  // ---------------- flow control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end

  assign out_valid = vld_q[LATENCY];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = init_q & adv;
  assign accept    = in_valid & in_ready;

  // valid, sign and tag travel in lock-step with the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      neg_q <= '0;
      for (int s = 1; s <= LATENCY; s++) tag_q[s] <= '0;
    end else if (adv) begin
      vld_q    <= {vld_q[LATENCY-1:1], accept};
      neg_q    <= {neg_q[LVLS:1], neg_d};
      tag_q[1] <= in_tag;
      for (int s = 2; s <= LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // ---------------- stage 1: magnitudes ----------------
  // Negating -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is the correct
  // unsigned magnitude in WIDTH bits.
  always_comb begin
    mag_a_d = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    mag_b_d = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    neg_d   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a_q <= '0;
      mag_b_q <= '0;
    end else if (adv) begin
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
    end
  end

  // ---------------- vedic levels ----------------
  // Level k holds an N x N grid of (2^k x 2^k) products, N = WIDTH / 2^k.
  // Grid entry (i,j) is (chunk i of a) * (chunk j of b); its four
  // sub-products are entries (2i|2i+1, 2j|2j+1) of the level below.
  for (genvar k = 1; k <= LVLS; k++) begin : g_lvl
    localparam int H  = 1 << (k - 1);  // half of this level's operand width
    localparam int N  = WIDTH >> k;    // chunks per operand
    localparam int PW = 4 * H;         // product width at this level
    localparam int SN = 2 * N;         // grid size of level k-1
    localparam int SW = 2 * H;         // product width of level k-1

    logic [N*N*PW-1:0] prod_d, prod_q;

    if (k == 1) begin : g_leaf
      logic [PW-1:0] p0, cr, p2;
      always_comb begin
        prod_d = '0;
        p0     = '0;
        cr     = '0;
        p2     = '0;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            // 2x2 vertical-and-crosswise: a0b0, (a1b0 + a0b1) << 1, a1b1 << 2
            p0 = {3'b000, mag_a_q[2*i]   & mag_b_q[2*j]};
            cr = {3'b000, mag_a_q[2*i+1] & mag_b_q[2*j]}
               + {3'b000, mag_a_q[2*i]   & mag_b_q[2*j+1]};
            p2 = {3'b000, mag_a_q[2*i+1] & mag_b_q[2*j+1]};
            prod_d[(i*N+j)*PW +: PW] = p0 + (cr << 1) + (p2 << 2);
          end
        end
      end
    end else begin : g_comb
      logic [PW-1:0] ll, lh, hl, hh;
      always_comb begin
        prod_d = '0;
        ll     = '0;
        lh     = '0;
        hl     = '0;
        hh     = '0;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            ll = PW'(g_lvl[k-1].prod_q[((2*i)*SN   + 2*j)  *SW +: SW]);
            lh = PW'(g_lvl[k-1].prod_q[((2*i)*SN   + 2*j+1)*SW +: SW]);
            hl = PW'(g_lvl[k-1].prod_q[((2*i+1)*SN + 2*j)  *SW +: SW]);
            hh = PW'(g_lvl[k-1].prod_q[((2*i+1)*SN + 2*j+1)*SW +: SW]);
            // the true product fits PW bits, so no term overflows
            prod_d[(i*N+j)*PW +: PW] = ll + ((lh + hl) << H) + (hh << (2*H));
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   prod_q <= '0;
      else if (adv) prod_q <= prod_d;
    end
  end

  // ---------------- final stage: sign restore ----------------
  assign p_mag = g_lvl[LVLS].prod_q;

  // -0 is 0, so a zero magnitude with neg=1 still yields 0
  always_comb begin
    out_p_d = neg_q[LVLS+1] ? -p_mag : p_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_p_q <= '0;
    else if (adv) out_p_q <= out_p_d;
  end

  assign out_p   = out_p_q;
  assign out_tag = tag_q[LATENCY];

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Bench for vedic_mul_pipe at WIDTH=8, TAG_W=4 (LATENCY = 5).
// Inputs are driven just after the falling edge, outputs sampled mid-low-phase.
module tb_vedic_mul_pipe;

  localparam int W   = 8;
  localparam int TW  = 4;
  localparam int LAT = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a, in_b;
  logic          in_signed;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] out_p;
  logic [TW-1:0] out_tag;

  vedic_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [TW+2*W-1:0] exp_q[$];   // {tag, product}
  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int stall_waits = 0;
  logic [TW+2*W-1:0] head;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: plain integer multiply with operands read per the mode
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    int x, y;
    x = s ? int'($signed(a)) : int'(a);
    y = s ? int'($signed(b)) : int'(b);
    return (2*W)'(x * y);
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] edge_vals [5];
    edge_vals[0] = 8'h00; edge_vals[1] = 8'hFF; edge_vals[2] = 8'h80;
    edge_vals[3] = 8'h7F; edge_vals[4] = 8'h01;
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 4)];
    return W'($urandom_range(0, 255));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      beats_seen++;
      chk("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        head = exp_q.pop_front();
        chk("out_p",   32'(out_p),   32'(head[2*W-1:0]));
        chk("out_tag", 32'(out_tag), 32'(head[TW+2*W-1:2*W]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_bp(input bit rbp);
    if (rbp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [TW-1:0] t, input logic [2*W-1:0] p, input bit rbp);
    int guard;
    guard = 0;
    @(negedge clk);
    set_bp(rbp);
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
    #1;
    while (!in_ready && guard < 100) begin
      stall_waits++;
      @(negedge clk);
      set_bp(rbp);
      #1;
      guard++;
    end
    chk("accept_in_time", {31'd0, in_ready}, 32'd1);
    exp_q.push_back({t, p});
    @(posedge clk);
  endtask

  task automatic idle(input int n, input bit rbp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_bp(rbp);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_rand(input bit rbp);
    logic [W-1:0] a, b;
    logic s;
    logic [TW-1:0] t;
    a = pick_operand();
    b = pick_operand();
    s = 1'($urandom_range(0, 1));
    t = TW'($urandom_range(0, 15));
    send(a, b, s, t, model(a, b, s), rbp);
  endtask

  // ---------------- directed sequence ----------------
  int seen0, waits0, drain;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;

    // reset values
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_p",     32'(out_p),     32'd0);
    chk("rst_out_tag",   32'(out_tag),   32'd0);
    #11 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // 0xFF * 0xFF, tag 3: out_valid exactly LAT cycles after the accept cycle
    send(8'hFF, 8'hFF, 1'b0, 4'd3, 16'hFE01, 1'b0);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      #1;
      chk("latency_out_valid", 32'(out_valid), (c == LAT) ? 32'd1 : 32'd0);
    end
    chk("ff_ff_product", 32'(out_p),   32'h0000FE01);
    chk("ff_ff_tag",     32'(out_tag), 32'd3);
    idle(3, 1'b0);

    // signed corners, back to back
    send(8'h80, 8'h80, 1'b1, 4'd1, 16'h4000, 1'b0);
    send(8'hFF, 8'h01, 1'b1, 4'd2, 16'hFFFF, 1'b0);
    send(8'h80, 8'h7F, 1'b1, 4'd4, 16'hC080, 1'b0);
    send(8'h00, 8'hFB, 1'b1, 4'd5, 16'h0000, 1'b0);
    idle(LAT + 3, 1'b0);
    chk("signed_drained", 32'(exp_q.size()), 32'd0);

    // 16 random beats back to back with out_ready=1
    seen0  = beats_seen;
    waits0 = stall_waits;
    for (int i = 0; i < 16; i++) send_rand(1'b0);
    idle(LAT + 3, 1'b0);
    chk("b2b_no_stall",  32'(stall_waits - waits0), 32'd0);
    chk("b2b_count",     32'(beats_seen - seen0),   32'd16);

    // fill the pipe with out_ready=0, hold 7 cycles, then release
    @(negedge clk);
    out_ready = 1'b0;
    seen0 = beats_seen;
    for (int i = 0; i < LAT; i++) send_rand(1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      #1;
      chk("hold_in_ready",  32'(in_ready),  32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_p",     32'(out_p),   32'(exp_q[0][2*W-1:0]));
      chk("hold_out_tag",   32'(out_tag), 32'(exp_q[0][TW+2*W-1:2*W]));
      @(negedge clk);
    end
    out_ready = 1'b1;
    idle(LAT + 5, 1'b0);
    chk("hold_count",   32'(beats_seen - seen0), 32'(LAT));
    chk("hold_drained", 32'(exp_q.size()),       32'd0);

    // asynchronous reset with 3 beats in flight
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd0);
    chk("midrst_out_p",     32'(out_p),     32'd0);
    chk("midrst_out_tag",   32'(out_tag),   32'd0);
    in_valid = 1'b0;
    exp_q.delete();
    #13 rst_n = 1'b1;
    for (int c = 0; c < 2 * LAT; c++) begin
      @(negedge clk); #1;
      chk("no_stale_beat", 32'(out_valid), 32'd0);
    end

    // random traffic: gaps on the input, random backpressure on the output
    seen0 = beats_seen;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1);
      send_rand(1'b1);
    end
    idle(1, 1'b1);
    out_ready = 1'b1;
    drain = 0;
    while (exp_q.size() != 0 && drain < 100) begin
      @(negedge clk);
      drain++;
    end
    idle(2, 1'b0);
    chk("random_drained", 32'(exp_q.size()),       32'd0);
    chk("random_count",   32'(beats_seen - seen0), 32'd300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
